// File: rtl/traffic_light_timed.sv
// Highway/farm-road light controller with built-in interval timer, all-red clearance,
// latched pedestrian WALK, farm-green max-out and night flashing; lamps are Moore-decoded.
module traffic_light_timed #(
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 16,
  parameter int T_YELLOW    = 4,
  parameter int T_ALLRED    = 2,
  parameter int T_FARM_MAX  = 12,
  parameter int T_WALK      = 8,
  parameter int FLASH_HALF  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c,
  input  logic       p,
  input  logic       night,
  output logic       HG,
  output logic       HY,
  output logic       HR,
  output logic       FG,
  output logic       FY,
  output logic       FR,
  output logic       walk,
  output logic [2:0] state
);

  localparam logic [2:0] S_HG    = 3'd0;
  localparam logic [2:0] S_HY    = 3'd1;
  localparam logic [2:0] S_AR1   = 3'd2;
  localparam logic [2:0] S_FG    = 3'd3;
  localparam logic [2:0] S_FY    = 3'd4;
  localparam logic [2:0] S_AR2   = 3'd5;
  localparam logic [2:0] S_FLASH = 3'd6;

  localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] L_FARM   = CNT_W'(T_FARM_MAX - 1);
  localparam logic [CNT_W-1:0] L_FLASH  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] WALK_MIN = CNT_W'(T_FARM_MAX - T_WALK);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;
  logic [2:0]       next_state;
  logic             ped_pend;
  logic             served;
  logic             flash_ph;
  logic             tz;
  logic             fg_entry;

  assign tz       = (count == '0);
  assign walk     = (state == S_FG) && served && (count >= WALK_MIN);
  assign fg_entry = (state == S_AR1) && (next_state == S_FG);

  // night is tested before c/walk so it wins in S_AR1 and S_FG
  always_comb begin
    next_state = state;
    case (state)
      S_HG:    if (tz && (c || ped_pend || night)) next_state = S_HY;
      S_HY:    if (tz) next_state = S_AR1;
      S_AR1:   if (tz) next_state = night ? S_FLASH : S_FG;
      S_FG:    if (tz || night || (!c && !walk)) next_state = S_FY;
      S_FY:    if (tz) next_state = S_AR2;
      S_AR2:   if (tz) next_state = S_HG;
      S_FLASH: if (tz && !night) next_state = S_AR2;
      default: next_state = S_HG;
    endcase
  end

  always_comb begin
    load_val = L_GREEN;
    case (next_state)
      S_HY, S_FY:   load_val = L_YELLOW;
      S_AR1, S_AR2: load_val = L_ALLRED;
      S_FG:         load_val = L_FARM;
      S_FLASH:      load_val = L_FLASH;
      default:      load_val = L_GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_HG;
      count    <= L_GREEN;
      ped_pend <= 1'b0;
      served   <= 1'b0;
      flash_ph <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state != state)
        count <= load_val;
      else if (state == S_FLASH && tz)
        count <= L_FLASH;
      else if (!tz)
        count <= count - CNT_W'(1);

      // a request arriving on the clearing edge is kept for the next farm phase
      ped_pend <= (ped_pend && !fg_entry) || p;

      if (fg_entry)
        served <= ped_pend;
      else if (state == S_FG && next_state != S_FG)
        served <= 1'b0;

      if (next_state == S_FLASH && state != S_FLASH)
        flash_ph <= 1'b1;
      else if (state == S_FLASH && tz)
        flash_ph <= ~flash_ph;
    end
  end

  always_comb begin
    HG = 1'b0; HY = 1'b0; HR = 1'b0;
    FG = 1'b0; FY = 1'b0; FR = 1'b0;
    case (state)
      S_HG:         begin HG = 1'b1; FR = 1'b1; end
      S_HY:         begin HY = 1'b1; FR = 1'b1; end
      S_AR1, S_AR2: begin HR = 1'b1; FR = 1'b1; end
      S_FG:         begin HR = 1'b1; FG = 1'b1; end
      S_FY:         begin HR = 1'b1; FY = 1'b1; end
      S_FLASH:      begin HY = flash_ph; FR = flash_ph; end
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_timed.sv
// Directed bench for traffic_light_timed: hand-counted dwell sequences checked every cycle
// with immediate assertions, plus lamp exclusivity/one-hot checks on every clock.
`timescale 1ns/1ps
module tb_traffic_light_timed;

  localparam logic [2:0] S_HG    = 3'd0;
  localparam logic [2:0] S_HY    = 3'd1;
  localparam logic [2:0] S_AR1   = 3'd2;
  localparam logic [2:0] S_FG    = 3'd3;
  localparam logic [2:0] S_FY    = 3'd4;
  localparam logic [2:0] S_AR2   = 3'd5;
  localparam logic [2:0] S_FLASH = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       c = 1'b0;
  logic       p = 1'b0;
  logic       night = 1'b0;
  logic       HG, HY, HR, FG, FY, FR, walk;
  logic [2:0] state;
  int         vectors = 0;
  int         miscompares = 0;

  traffic_light_timed dut (
    .clk(clk), .reset(reset), .c(c), .p(p), .night(night),
    .HG(HG), .HY(HY), .HR(HR), .FG(FG), .FY(FY), .FR(FR),
    .walk(walk), .state(state)
  );

  always #5 clk = ~clk;

  // {HG,HY,HR,FG,FY,FR,walk}; x is walk in S_FG and the flash phase in S_FLASH
  function automatic logic [6:0] lamps_for(input logic [2:0] s, input logic x);
    case (s)
      S_HG:         return 7'b1000010;
      S_HY:         return 7'b0100010;
      S_AR1, S_AR2: return 7'b0010010;
      S_FG:         return {6'b001100, x};
      S_FY:         return 7'b0010100;
      S_FLASH:      return {1'b0, x, 3'b000, x, 1'b0};
      default:      return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("cross_road_excl", {7'd0, (HG | HY) & (FG | FY)}, 8'd0);
    if (state != S_FLASH) begin
      chk("hw_onehot", 8'($countones({HG, HY, HR})), 8'd1);
      chk("farm_onehot", 8'($countones({FG, FY, FR})), 8'd1);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] s, input int n, input logic x);
    for (int i = 0; i < n; i++) begin
      chk({tag, " state"}, {5'd0, state}, {5'd0, s});
      chk({tag, " lamps"}, {1'b0, HG, HY, HR, FG, FY, FR, walk}, {1'b0, lamps_for(s, x)});
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; c = 1'b0; p = 1'b0; night = 1'b0;
    #1;
    chk("reset state", {5'd0, state}, 8'd0);
    chk("reset lamps", {1'b0, HG, HY, HR, FG, FY, FR, walk}, {1'b0, lamps_for(S_HG, 1'b0)});
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // idle: no demand keeps highway green
    do_reset();
    run("t1 idle", S_HG, 100, 1'b0);

    // car held: full cycle with farm max-out
    do_reset();
    c = 1'b1;
    run("t2 hg", S_HG, 16, 1'b0);
    run("t2 hy", S_HY, 4, 1'b0);
    run("t2 ar1", S_AR1, 2, 1'b0);
    run("t2 fg", S_FG, 12, 1'b0);
    run("t2 fy", S_FY, 4, 1'b0);
    run("t2 ar2", S_AR2, 2, 1'b0);
    run("t2 hg2", S_HG, 1, 1'b0);
    c = 1'b0;

    // pedestrian pulse: WALK for 8, FG ends on its 9th sample, no second phase
    do_reset();
    run("t3 hg", S_HG, 3, 1'b0);
    p = 1'b1;
    run("t3 hg_p", S_HG, 1, 1'b0);
    p = 1'b0;
    run("t3 hg", S_HG, 12, 1'b0);
    run("t3 hy", S_HY, 4, 1'b0);
    run("t3 ar1", S_AR1, 2, 1'b0);
    run("t3 walk", S_FG, 8, 1'b1);
    run("t3 fg_end", S_FG, 1, 1'b0);
    run("t3 fy", S_FY, 4, 1'b0);
    run("t3 ar2", S_AR2, 2, 1'b0);
    run("t3 hg_idle", S_HG, 40, 1'b0);

    // night: flashing, p latched through flash and served afterwards
    do_reset();
    night = 1'b1;
    run("t4 hg", S_HG, 16, 1'b0);
    run("t4 hy", S_HY, 4, 1'b0);
    run("t4 ar1", S_AR1, 2, 1'b0);
    run("t4 flash_on", S_FLASH, 4, 1'b1);
    run("t4 flash_off", S_FLASH, 4, 1'b0);
    p = 1'b1;
    run("t4 flash_on_p", S_FLASH, 1, 1'b1);
    p = 1'b0;
    run("t4 flash_on", S_FLASH, 3, 1'b1);
    night = 1'b0;
    run("t4 flash_last", S_FLASH, 4, 1'b0);
    run("t4 ar2", S_AR2, 2, 1'b0);
    run("t4 hg", S_HG, 16, 1'b0);
    run("t4 hy", S_HY, 4, 1'b0);
    run("t4 ar1", S_AR1, 2, 1'b0);
    run("t4 walk", S_FG, 8, 1'b1);
    run("t4 fg_end", S_FG, 1, 1'b0);
    run("t4 fy", S_FY, 4, 1'b0);
    run("t4 ar2b", S_AR2, 2, 1'b0);
    run("t4 hg_idle", S_HG, 5, 1'b0);

    // night overrides a car in S_FG and in S_AR1
    do_reset();
    c = 1'b1;
    run("tn hg", S_HG, 16, 1'b0);
    run("tn hy", S_HY, 4, 1'b0);
    run("tn ar1", S_AR1, 2, 1'b0);
    run("tn fg", S_FG, 3, 1'b0);
    night = 1'b1;
    run("tn fg_night", S_FG, 1, 1'b0);
    run("tn fy", S_FY, 4, 1'b0);
    run("tn ar2", S_AR2, 2, 1'b0);
    run("tn hg", S_HG, 16, 1'b0);
    run("tn hy", S_HY, 4, 1'b0);
    run("tn ar1", S_AR1, 2, 1'b0);
    run("tn flash", S_FLASH, 2, 1'b1);

    // asynchronous reset during WALK
    do_reset();
    p = 1'b1;
    run("t5 hg_p", S_HG, 1, 1'b0);
    p = 1'b0;
    run("t5 hg", S_HG, 15, 1'b0);
    run("t5 hy", S_HY, 4, 1'b0);
    run("t5 ar1", S_AR1, 2, 1'b0);
    run("t5 walk", S_FG, 2, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5 async state", {5'd0, state}, 8'd0);
    chk("t5 async lamps", {1'b0, HG, HY, HR, FG, FY, FR, walk}, {1'b0, lamps_for(S_HG, 1'b0)});
    tick();
    chk("t5 held state", {5'd0, state}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
